mux_arbiter_2to1: RTL and testbench
===================================

MUX_ARBITER_2TO1 -- requirements
Module: mux_arbiter_2to1

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the data path width.
REQ-002 Parameter MAX_HOLD, default 4, SHALL set the maximum consecutive beats one owner keeps the mux while the other requester waits; legal range 1..15.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 req_0  input  1  SHALL indicate that requester 0 has a beat on din_0.
REQ-006 din_0  input  DATA_W  SHALL carry requester 0 data.
REQ-007 gnt_0  output  1  SHALL signal acceptance of the din_0 beat this cycle (combinational).
REQ-008 req_1, din_1, gnt_1 SHALL mirror REQ-005..007 for requester 1.
REQ-009 out_ready  input  1  SHALL indicate the downstream sink accepts mux_out this cycle.
REQ-010 out_valid  output  1  SHALL indicate mux_out holds a valid beat (registered).
REQ-011 mux_out  output  DATA_W  SHALL carry the selected beat (registered).
REQ-012 sel  output  1  SHALL be 1 in OWN1 and 0 otherwise (registered, from state).

Function
REQ-013 FSM SHALL have states IDLE, OWN0, OWN1.
REQ-014 Output slot is free when !out_valid || out_ready.
REQ-015 gnt_x SHALL equal (state==OWNx) && req_x && slot_free; gnt_0 and gnt_1 SHALL never both be 1.
REQ-016 Each granted beat SHALL load mux_out with din_x and set out_valid one cycle later (latency 1).
REQ-017 out_valid SHALL clear when out_ready=1 and no grant occurs that cycle; while out_ready=0, mux_out and out_valid SHALL stay stable.
REQ-018 IDLE: on a single request, go to that OWNx next cycle; on both requests, go to the owner opposite last_owner; on none, stay. No grant issues in IDLE, so arbitration costs 1 cycle.
REQ-019 OWNx: hold_cnt (4 bits) SHALL increment on every gnt_x.
REQ-020 OWNx SHALL go to OWNy when req_y=1 and either req_x=0 or hold_cnt has reached MAX_HOLD; it SHALL go to IDLE when req_x=0 and req_y=0; otherwise it SHALL stay.
REQ-021 On every exit from OWNx, hold_cnt SHALL clear to 0 and last_owner SHALL become x.
REQ-022 On a hold_cnt==MAX_HOLD switch, the beat granted in that same cycle SHALL complete normally; no beat SHALL be dropped or duplicated.
REQ-023 With MAX_HOLD=1 and both requesting continuously, ownership SHALL alternate every beat, with no IDLE cycle between owners.
REQ-024 While out_ready=0, hold_cnt SHALL NOT advance (no grants) and the FSM SHALL keep its owner unless req_x drops.

Reset
REQ-025 Reset SHALL force state=IDLE, hold_cnt=0, last_owner=1, out_valid=0, mux_out=0, and sel=0, immediately and independently of clk.
REQ-026 Reset asserted mid-transfer SHALL discard the beat held in the output register; after reset, the first simultaneous request SHALL be awarded to requester 0.

Structure
REQ-027 Package mux_arb_pkg SHALL hold the state enum (IDLE, OWN0, OWN1) and the hold-counter width constant.
REQ-028 The datapath SHALL instantiate one sub-module, mux2_w, a DATA_W-wide 2:1 select driven by sel; the FSM, counter and output register SHALL stay in mux_arbiter_2to1.

Verification
REQ-029 Reset, then req_0=1 with din_0=0x11, out_ready=1 -> cycle 1: OWN0; cycle 1: gnt_0=1; cycle 2: out_valid=1, mux_out=0x11.
REQ-030 Both requesters continuous, MAX_HOLD=4, out_ready=1 -> granted beat order 0,0,0,0,1,1,1,1,0...; sel toggles every 4 beats.
REQ-031 OWN1 streaming, out_ready=0 for 3 cycles -> gnt_1=0, mux_out and out_valid stable, hold_cnt frozen; streaming resumes on the cycle out_ready returns to 1.
REQ-032 Owner 0 drops req_0 while req_1=1 -> next cycle OWN1, hold_cnt=0, last_owner=0; no intervening IDLE cycle.
REQ-033 Assert reset with out_valid=1 and mux_out=0xA5 -> out_valid=0 and mux_out=0 before the next clk edge; then apply simultaneous requests -> requester 0 wins.
REQ-034 MAX_HOLD=1 and random req and out_ready over 10k cycles -> scoreboard shows no lost or duplicated beats, and the gnt_0 and gnt_1 one-hot-or-zero assertion always holds.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// -----------------------------------------------------------------------------
// mux_arb_pkg
// Shared types and constants for the 2:1 arbitrated multiplexer.
//   arb_state_t : arbiter FSM states (IDLE, OWN0, OWN1)
//   HOLD_W      : width of the per-owner beat counter
//   HOLD_SAT    : saturation value of that counter
// -----------------------------------------------------------------------------
package mux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam int HOLD_W = 4;
    localparam logic [HOLD_W-1:0] HOLD_SAT = '1;

endpackage : mux_arb_pkg

// File: rtl/mux_arbiter_2to1_mux2_w.sv
// -----------------------------------------------------------------------------
// mux2_w
// DATA_W-wide 2:1 select.
//   sel  : 0 picks in_0, 1 picks in_1
//   in_0 : candidate data from requester 0
//   in_1 : candidate data from requester 1
//   y    : selected data (combinational)
// -----------------------------------------------------------------------------
module mux2_w #(
    parameter int DATA_W = 8
) (
    input  logic              sel,
    input  logic [DATA_W-1:0] in_0,
    input  logic [DATA_W-1:0] in_1,
    output logic [DATA_W-1:0] y
);

    assign y = sel ? in_1 : in_0;

endmodule : mux2_w

// File: rtl/mux_arbiter_2to1.sv
// -----------------------------------------------------------------------------
// mux_arbiter_2to1
// Two requesters share one registered output slot. An FSM hands ownership to
// one requester at a time; an owner streams beats until it stops requesting or
// has sent MAX_HOLD beats while the other side waits.
//   clk, reset       : rising-edge clock, asynchronous active-high reset
//   req_0/din_0/gnt_0: requester 0 handshake (gnt_0 is combinational)
//   req_1/din_1/gnt_1: requester 1 handshake (gnt_1 is combinational)
//   out_ready        : downstream accepts mux_out this cycle
//   out_valid        : mux_out holds a valid beat (registered)
//   mux_out          : selected beat (registered)
//   sel              : 1 while owner is requester 1 (registered)
// -----------------------------------------------------------------------------
module mux_arbiter_2to1
    import mux_arb_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_0,
    input  logic [DATA_W-1:0] din_0,
    output logic              gnt_0,
    input  logic              req_1,
    input  logic [DATA_W-1:0] din_1,
    output logic              gnt_1,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] mux_out,
    output logic              sel
);

    localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);

    arb_state_t        state, state_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt, hold_cnt_inc;
    logic              last_owner, last_owner_nxt;
    logic              slot_free;
    logic              grant;
    logic              hold_reached;
    logic [DATA_W-1:0] sel_data;

    // sel always mirrors (state == OWN1), so the mux already points at the
    // current owner in the cycle its grant fires.
    mux2_w #(
        .DATA_W (DATA_W)
    ) u_mux (
        .sel  (sel),
        .in_0 (din_0),
        .in_1 (din_1),
        .y    (sel_data)
    );

    assign slot_free = !out_valid || out_ready;
    assign gnt_0     = (state == OWN0) && req_0 && slot_free;
    assign gnt_1     = (state == OWN1) && req_1 && slot_free;
    assign grant     = gnt_0 || gnt_1;

    // Count including this cycle's beat, so the switch lands right after the
    // MAX_HOLD-th beat and that beat still completes. Saturates rather than
    // wrapping when the other side never asks.
    assign hold_cnt_inc = (grant && (hold_cnt != HOLD_SAT)) ? hold_cnt + 4'd1 : hold_cnt;
    assign hold_reached = (hold_cnt_inc >= MAX_HOLD_C);

    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt      = state;
        hold_cnt_nxt   = hold_cnt_inc;
        last_owner_nxt = last_owner;

        unique case (state)
            IDLE: begin
                if (req_0 && req_1) begin
                    state_nxt = last_owner ? OWN0 : OWN1;
                end else if (req_0) begin
                    state_nxt = OWN0;
                end else if (req_1) begin
                    state_nxt = OWN1;
                end
            end
            OWN0: begin
                if (req_1 && (!req_0 || hold_reached)) begin
                    state_nxt = OWN1;
                end else if (!req_0 && !req_1) begin
                    state_nxt = IDLE;
                end
            end
            OWN1: begin
                if (req_0 && (!req_1 || hold_reached)) begin
                    state_nxt = OWN0;
                end else if (!req_0 && !req_1) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Leaving an owner state restarts the count and remembers who owned.
        if ((state != IDLE) && (state_nxt != state)) begin
            hold_cnt_nxt   = '0;
            last_owner_nxt = (state == OWN1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    // NOTE: the data register is reset too, so a held beat is discarded and
    // mux_out reads zero immediately on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            last_owner <= 1'b1;
            sel        <= 1'b0;
            out_valid  <= 1'b0;
            mux_out    <= '0;
        end else begin
            state      <= state_nxt;
            hold_cnt   <= hold_cnt_nxt;
            last_owner <= last_owner_nxt;
            sel        <= (state_nxt == OWN1);
            if (grant) begin
                out_valid <= 1'b1;
                mux_out   <= sel_data;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule : mux_arbiter_2to1

// File: tb/tb_mux_arbiter_2to1.sv
// -----------------------------------------------------------------------------
// tb_mux_arbiter_2to1
// Directed table for the default instance (MAX_HOLD=4), hand sequences for
// hold-limit rotation and asynchronous reset, and a MAX_HOLD=1 instance driven
// with random requests and backpressure against a beat scoreboard.
// -----------------------------------------------------------------------------
module tb_mux_arbiter_2to1;

    logic       clk = 1'b0;
    logic       reset;

    // Default instance (MAX_HOLD = 4)
    logic       req_0, req_1, out_ready;
    logic [7:0] din_0, din_1;
    logic       gnt_0, gnt_1, out_valid, sel;
    logic [7:0] mux_out;

    // MAX_HOLD = 1 instance
    logic       h1_req_0, h1_req_1, h1_out_ready;
    logic [7:0] h1_din_0, h1_din_1;
    logic       h1_gnt_0, h1_gnt_1, h1_out_valid, h1_sel;
    logic [7:0] h1_mux_out;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    mux_arbiter_2to1 #(.DATA_W(8), .MAX_HOLD(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_0     (req_0),
        .din_0     (din_0),
        .gnt_0     (gnt_0),
        .req_1     (req_1),
        .din_1     (din_1),
        .gnt_1     (gnt_1),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .mux_out   (mux_out),
        .sel       (sel)
    );

    mux_arbiter_2to1 #(.DATA_W(8), .MAX_HOLD(1)) dut_h1 (
        .clk       (clk),
        .reset     (reset),
        .req_0     (h1_req_0),
        .din_0     (h1_din_0),
        .gnt_0     (h1_gnt_0),
        .req_1     (h1_req_1),
        .din_1     (h1_din_1),
        .gnt_1     (h1_gnt_1),
        .out_ready (h1_out_ready),
        .out_valid (h1_out_valid),
        .mux_out   (h1_mux_out),
        .sel       (h1_sel)
    );

    typedef struct packed {
        logic       r0;
        logic       r1;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       rdy;
        logic       g0;
        logic       g1;
        logic       sel;
        logic       ov;
        logic [7:0] mo;
        logic [3:0] cnt;
        logic       lo;
    } vec_t;

    vec_t vecs [15];

    function automatic vec_t mk(input logic r0, input logic r1, input logic [7:0] d0,
                                input logic [7:0] d1, input logic rdy, input logic g0,
                                input logic g1, input logic s, input logic ov,
                                input logic [7:0] mo, input logic [3:0] cnt, input logic lo);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.d0 = d0; v.d1 = d1; v.rdy = rdy;
        v.g0 = g0; v.g1 = g1; v.sel = s; v.ov = ov; v.mo = mo; v.cnt = cnt; v.lo = lo;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        req_0 = 1'b0; req_1 = 1'b0; din_0 = 8'h00; din_1 = 8'h00; out_ready = 1'b0;
        h1_req_0 = 1'b0; h1_req_1 = 1'b0; h1_din_0 = 8'h00; h1_din_1 = 8'h00;
        h1_out_ready = 1'b0;
    endtask

    // Ends on a falling edge with reset released.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Scoreboard state for the MAX_HOLD=1 instance
    logic [7:0] sb_q [$];
    logic [6:0] seq0 = '0;
    logic [6:0] seq1 = '0;
    logic       prev_ov  = 1'b0;
    logic       prev_rdy = 1'b0;
    logic [7:0] prev_mo  = '0;
    int         n_pushed = 0;
    int         n_popped = 0;

    task automatic rand_cycle(input bit rnd);
        logic [7:0] exp_beat;
        @(negedge clk);
        if (rnd) begin
            h1_req_0     = ($urandom_range(0, 3) != 0);
            h1_req_1     = ($urandom_range(0, 3) != 0);
            h1_out_ready = ($urandom_range(0, 9) < 7);
        end else begin
            h1_req_0     = 1'b0;
            h1_req_1     = 1'b0;
            h1_out_ready = 1'b1;
        end
        h1_din_0 = {1'b0, seq0};
        h1_din_1 = {1'b1, seq1};
        #1;
        check("rnd_onehot", 32'(h1_gnt_0 && h1_gnt_1), 32'd0);
        if (prev_ov && !prev_rdy) begin
            check("rnd_hold_valid", 32'(h1_out_valid), 32'd1);
            check("rnd_hold_data", 32'(h1_mux_out), 32'(prev_mo));
        end
        if (h1_out_valid && h1_out_ready) begin
            check("rnd_pending", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                exp_beat = sb_q.pop_front();
                n_popped++;
                check("rnd_beat", 32'(h1_mux_out), 32'(exp_beat));
            end
        end
        if (h1_gnt_0) begin
            sb_q.push_back(h1_din_0);
            seq0++;
            n_pushed++;
        end
        if (h1_gnt_1) begin
            sb_q.push_back(h1_din_1);
            seq1++;
            n_pushed++;
        end
        prev_ov  = h1_out_valid;
        prev_rdy = h1_out_ready;
        prev_mo  = h1_mux_out;
    endtask

    initial begin
        int  ngr;
        int  first_c;
        int  last_c;
        logic own  [12];
        logic gsel [12];
        logic [1:0] exp_g;

        // Directed table, default instance. Each row is one cycle; expected
        // values are what the outputs show during that cycle.
        //            r0 r1 d0     d1     rdy g0 g1 sel ov mo     cnt lo
        vecs[0]  = mk(1, 0, 8'h11, 8'h00, 1,  0, 0, 0,  0, 8'h00, 0,  1);
        vecs[1]  = mk(1, 0, 8'h11, 8'h00, 1,  1, 0, 0,  0, 8'h00, 0,  1);
        vecs[2]  = mk(0, 0, 8'h00, 8'h00, 1,  0, 0, 0,  1, 8'h11, 1,  1);
        vecs[3]  = mk(1, 1, 8'hA0, 8'hB0, 1,  0, 0, 0,  0, 8'h11, 0,  0);
        vecs[4]  = mk(1, 1, 8'hA0, 8'hB0, 1,  0, 1, 1,  0, 8'h11, 0,  0);
        vecs[5]  = mk(1, 1, 8'hA0, 8'hB1, 1,  0, 1, 1,  1, 8'hB0, 1,  0);
        vecs[6]  = mk(1, 1, 8'hA0, 8'hB2, 0,  0, 0, 1,  1, 8'hB1, 2,  0);
        vecs[7]  = mk(1, 1, 8'hA0, 8'hB2, 0,  0, 0, 1,  1, 8'hB1, 2,  0);
        vecs[8]  = mk(1, 1, 8'hA0, 8'hB2, 1,  0, 1, 1,  1, 8'hB1, 2,  0);
        vecs[9]  = mk(1, 1, 8'hA0, 8'hB3, 1,  0, 1, 1,  1, 8'hB2, 3,  0);
        vecs[10] = mk(1, 1, 8'hA1, 8'hB3, 1,  1, 0, 0,  1, 8'hB3, 0,  1);
        vecs[11] = mk(0, 1, 8'hA1, 8'hB4, 1,  0, 0, 0,  1, 8'hA1, 1,  1);
        vecs[12] = mk(0, 1, 8'h00, 8'hB4, 1,  0, 1, 1,  0, 8'hA1, 0,  0);
        vecs[13] = mk(0, 0, 8'h00, 8'h00, 1,  0, 0, 1,  1, 8'hB4, 1,  0);
        vecs[14] = mk(0, 0, 8'h00, 8'h00, 1,  0, 0, 0,  0, 8'hB4, 0,  1);

        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_mux_out", 32'(mux_out), 32'd0);
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_gnt", 32'({gnt_1, gnt_0}), 32'd0);
        check("rst_hold_cnt", 32'(dut.hold_cnt), 32'd0);
        check("rst_last_owner", 32'(dut.last_owner), 32'd1);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            req_0 = vecs[i].r0; req_1 = vecs[i].r1;
            din_0 = vecs[i].d0; din_1 = vecs[i].d1;
            out_ready = vecs[i].rdy;
            #1;
            check($sformatf("v%0d_gnt_0", i), 32'(gnt_0), 32'(vecs[i].g0));
            check($sformatf("v%0d_gnt_1", i), 32'(gnt_1), 32'(vecs[i].g1));
            check($sformatf("v%0d_sel", i), 32'(sel), 32'(vecs[i].sel));
            check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].ov));
            check($sformatf("v%0d_mux_out", i), 32'(mux_out), 32'(vecs[i].mo));
            check($sformatf("v%0d_hold_cnt", i), 32'(dut.hold_cnt), 32'(vecs[i].cnt));
            check($sformatf("v%0d_last_owner", i), 32'(dut.last_owner), 32'(vecs[i].lo));
            @(negedge clk);
        end

        // Both requesters continuous, MAX_HOLD=4: owners 0,0,0,0,1,1,1,1,0,...
        do_reset();
        req_0 = 1'b1; req_1 = 1'b1; din_0 = 8'h0C; din_1 = 8'hD1; out_ready = 1'b1;
        ngr = 0; first_c = -1; last_c = -1;
        for (int c = 0; c < 40 && ngr < 12; c++) begin
            #1;
            if (gnt_0 || gnt_1) begin
                if (first_c < 0) first_c = c;
                last_c    = c;
                own[ngr]  = gnt_1;
                gsel[ngr] = sel;
                ngr++;
            end
            @(negedge clk);
        end
        check("rot_grant_count", 32'(ngr), 32'd12);
        check("rot_first_grant_cycle", 32'(first_c), 32'd1);
        check("rot_no_gaps", 32'(last_c - first_c), 32'd11);
        for (int k = 0; k < ngr; k++) begin
            check($sformatf("rot_owner_%0d", k), 32'(own[k]), 32'((k / 4) % 2));
            check($sformatf("rot_sel_%0d", k), 32'(gsel[k]), 32'((k / 4) % 2));
        end

        // Asynchronous reset with a beat held in the output register.
        do_reset();
        req_0 = 1'b1; din_0 = 8'hA5; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("arst_pre_valid", 32'(out_valid), 32'd1);
        check("arst_pre_data", 32'(mux_out), 32'hA5);
        #2 reset = 1'b1;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_data", 32'(mux_out), 32'd0);
        check("arst_sel", 32'(sel), 32'd0);
        #1 reset = 1'b0;
        req_0 = 1'b1; req_1 = 1'b1; din_0 = 8'h3C; din_1 = 8'hC3; out_ready = 1'b1;
        @(negedge clk);
        #1;
        check("arst_first_win", 32'({gnt_1, gnt_0}), 32'b01);

        // MAX_HOLD=1, both continuous: strict alternation with no idle gap.
        do_reset();
        for (int c = 0; c < 9; c++) begin
            h1_req_0 = 1'b1; h1_req_1 = 1'b1; h1_out_ready = 1'b1;
            h1_din_0 = 8'h40; h1_din_1 = 8'hC0;
            #1;
            if (c == 0) exp_g = 2'b00;
            else        exp_g = (((c - 1) % 2) == 0) ? 2'b01 : 2'b10;
            check($sformatf("alt_gnt_%0d", c), 32'({h1_gnt_1, h1_gnt_0}), 32'(exp_g));
            @(negedge clk);
        end

        // MAX_HOLD=1 random traffic against the scoreboard.
        do_reset();
        for (int n = 0; n < 10000; n++) rand_cycle(1'b1);
        for (int n = 0; n < 6; n++) rand_cycle(1'b0);
        check("rnd_drained", 32'(sb_q.size()), 32'd0);
        check("rnd_beat_count", 32'(n_popped), 32'(n_pushed));
        check("rnd_activity", 32'(n_popped > 1000), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_mux_arbiter_2to1
